// File: rtl/apb_regfile_slave_if.sv
// APB bus bundle between the upstream bridge (master) and the register-file slave.
// The slave modport has the transfer controls as inputs and the completion response as outputs.
interface apb_regfile_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] paddr_i;
  logic                  psel_i;
  logic                  penable_i;
  logic                  pwrite_i;
  logic [DATA_WIDTH-1:0] pwdata_i;
  logic [3:0]            pstrb_i;
  logic                  pready_o;
  logic [DATA_WIDTH-1:0] prdata_o;
  logic                  pslverr_o;

  modport master (
    output paddr_i, psel_i, penable_i, pwrite_i, pwdata_i, pstrb_i,
    input  pready_o, prdata_o, pslverr_o
  );

  modport slave (
    input  paddr_i, psel_i, penable_i, pwrite_i, pwdata_i, pstrb_i,
    output pready_o, prdata_o, pslverr_o
  );
endinterface

// File: rtl/apb_regfile_slave.sv
// APB register-file slave: NUM_REGS x 32-bit registers (register 0 is a read-only ID),
// programmable wait states, byte-lane write strobes and slave-error responses.
module apb_regfile_slave #(
  parameter int          ADDR_WIDTH  = 32,
  parameter int          DATA_WIDTH  = 32,
  parameter int          NUM_REGS    = 16,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
  input  logic               pclk_i,
  input  logic               prst_i,
  apb_regfile_slave_if.slave bus
);
  localparam int IDX_W = ADDR_WIDTH - 2;
  localparam int SEL_W = $clog2(NUM_REGS);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  logic [IDX_W-1:0]      index;
  logic [SEL_W-1:0]      sel;
  logic                  err;
  logic                  complete;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] rdata;

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_val,
    input logic [DATA_WIDTH-1:0] new_val,
    input logic [3:0]            lanes
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (lanes[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  assign index = bus.paddr_i[ADDR_WIDTH-1:2];
  assign sel   = index[SEL_W-1:0];

  // Any out-of-range index is flagged here, so the truncated sel is only trusted when err is low.
  assign err = (bus.paddr_i[1:0] != 2'b00)
            || (index >= IDX_W'(NUM_REGS))
            || (bus.pwrite_i && (index == '0));

  assign complete = (state_q == ACCESS) && bus.psel_i && bus.penable_i && (cnt_q == 8'd0);
  assign wr_en    = complete && bus.pwrite_i && !err;

  assign rdata = (index == '0) ? ID_VALUE : regs_q[sel];

  assign bus.pready_o  = complete;
  assign bus.pslverr_o = complete && err;
  assign bus.prdata_o  = (complete && !bus.pwrite_i && !err) ? rdata : '0;

  // Slot 0 is never stored: reads of index 0 come from ID_VALUE.
  assign regs_d[0] = '0;

  generate
    for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_reg
      logic hit;
      assign hit        = wr_en && (sel == SEL_W'(gi));
      assign regs_d[gi] = merge_bytes(regs_q[gi], bus.pwdata_i, hit ? bus.pstrb_i : 4'b0000);
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.psel_i && !bus.penable_i) begin
          state_d = ACCESS;
          cnt_d   = 8'(WAIT_CYCLES);
        end
      end
      ACCESS: begin
        if (!bus.psel_i) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else if (!bus.penable_i) begin
          cnt_d = 8'(WAIT_CYCLES);
        end else if (cnt_q == 8'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge pclk_i or negedge prst_i) begin
    if (!prst_i) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end
endmodule

// File: tb/tb_apb_regfile_slave.sv
// Directed bench for apb_regfile_slave: a 2-wait-state instance for the main vectors
// and a zero-wait instance for back-to-back transfers.
module tb_apb_regfile_slave;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dut_sel = 1'b0;
  logic [31:0] paddr = '0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = '0;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  apb_regfile_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus2 ();
  apb_regfile_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();

  assign bus2.paddr_i   = paddr;
  assign bus2.psel_i    = psel && !dut_sel;
  assign bus2.penable_i = penable;
  assign bus2.pwrite_i  = pwrite;
  assign bus2.pwdata_i  = pwdata;
  assign bus2.pstrb_i   = pstrb;
  assign bus0.paddr_i   = paddr;
  assign bus0.psel_i    = psel && dut_sel;
  assign bus0.penable_i = penable;
  assign bus0.pwrite_i  = pwrite;
  assign bus0.pwdata_i  = pwdata;
  assign bus0.pstrb_i   = pstrb;

  apb_regfile_slave #(.WAIT_CYCLES(2)) dut2 (.pclk_i(clk), .prst_i(rst_n), .bus(bus2.slave));
  apb_regfile_slave #(.WAIT_CYCLES(0)) dut0 (.pclk_i(clk), .prst_i(rst_n), .bus(bus0.slave));

  logic        cur_ready, cur_err;
  logic [31:0] cur_rdata;
  assign cur_ready = dut_sel ? bus0.pready_o  : bus2.pready_o;
  assign cur_err   = dut_sel ? bus0.pslverr_o : bus2.pslverr_o;
  assign cur_rdata = dut_sel ? bus0.prdata_o  : bus2.prdata_o;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Entered at posedge+1; returns at posedge+1 just after the completing edge, psel still high.
  task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s,
                      output logic ok, output int n, output logic [31:0] rd, output logic er);
    paddr = a; pwrite = w; pwdata = d; pstrb = s; psel = 1'b1; penable = 1'b0;
    @(posedge clk); #1 penable = 1'b1;
    n = 0; ok = 1'b0; rd = '0; er = 1'b0;
    while (!ok && n < 20) begin
      n++;
      @(negedge clk);
      if (cur_ready) begin
        ok = 1'b1; rd = cur_rdata; er = cur_err;
      end
      @(posedge clk); #1;
    end
    $display("xfer dut=%0d %s addr=%h wdata=%h strb=%h -> ready=%0b cycles=%0d rdata=%h err=%0b",
             dut_sel ? 0 : 2, w ? "WR" : "RD", a, d, s, ok, n, rd, er);
  endtask

  task automatic idle();
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic reset_mid(input logic [31:0] a, input logic w, input logic [31:0] d,
                           input logic [31:0] exp_rd);
    paddr = a; pwrite = w; pwdata = d; pstrb = 4'hF; psel = 1'b1; penable = 1'b0;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstmid_ready_before", 32'(cur_ready), 32'd1);
    chk("rstmid_rdata_before", cur_rdata, exp_rd);
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid_ready_async", 32'(cur_ready), 32'd0);
    chk("rstmid_err_async", 32'(cur_err), 32'd0);
    chk("rstmid_rdata_async", cur_rdata, 32'd0);
    $display("reset mid-%s addr=%h: ready=%0b rdata=%h err=%0b", w ? "write" : "read", a,
             cur_ready, cur_rdata, cur_err);
    psel = 1'b0; penable = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    logic        ok, er;
    logic [31:0] rd;
    int          n, t0;

    vecs[0]  = '{32'h0C, 1'b1, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0};
    vecs[1]  = '{32'h0C, 1'b0, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{32'h0C, 1'b1, 32'h1122_3344, 4'h5, 32'h0,         1'b0};
    vecs[3]  = '{32'h0C, 1'b0, 32'h0,         4'h0, 32'hDE22_BE44, 1'b0};
    vecs[4]  = '{32'h40, 1'b0, 32'h0,         4'h0, 32'h0,         1'b1};
    vecs[5]  = '{32'h00, 1'b1, 32'h1234_5678, 4'hF, 32'h0,         1'b1};
    vecs[6]  = '{32'h00, 1'b0, 32'h0,         4'h0, 32'hA5B0_0001, 1'b0};
    vecs[7]  = '{32'h06, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h0,         1'b1};
    vecs[8]  = '{32'h3C, 1'b1, 32'hFFFF_FFFF, 4'h0, 32'h0,         1'b0};
    vecs[9]  = '{32'h3C, 1'b0, 32'h0,         4'h0, 32'h0,         1'b0};
    vecs[10] = '{32'h3C, 1'b1, 32'hAABB_CCDD, 4'h8, 32'h0,         1'b0};
    vecs[11] = '{32'h3C, 1'b0, 32'h0,         4'h0, 32'hAA00_0000, 1'b0};

    #2;
    chk("reset_ready", 32'(bus2.pready_o), 32'd0);
    chk("reset_err", 32'(bus2.pslverr_o), 32'd0);
    chk("reset_rdata", bus2.prdata_o, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    reset_mid(32'h0C, 1'b1, 32'hDEAD_BEEF, 32'h0);
    xfer(32'h0C, 1'b0, 32'h0, 4'h0, ok, n, rd, er); idle();
    chk("rstmid_write_dropped", rd, 32'h0);
    reset_mid(32'h00, 1'b0, 32'h0, 32'hA5B0_0001);

    for (int i = 0; i < 12; i++) begin
      xfer(vecs[i].addr, vecs[i].wr, vecs[i].wdata, vecs[i].strb, ok, n, rd, er);
      idle();
      chk($sformatf("vec%0d_ready", i), 32'(ok), 32'd1);
      chk($sformatf("vec%0d_cycles", i), 32'(n), 32'd3);
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
    end

    // Abort: drop psel after one access cycle of a write to 0x10.
    paddr = 32'h10; pwrite = 1'b1; pwdata = 32'hCAFE_F00D; pstrb = 4'hF; psel = 1'b1; penable = 1'b0;
    @(posedge clk); #1 penable = 1'b1;
    @(negedge clk);
    chk("abort_ready_acc1", 32'(cur_ready), 32'd0);
    @(posedge clk); #1 psel = 1'b0;
    @(negedge clk);
    chk("abort_ready_dropped", 32'(cur_ready), 32'd0);
    $display("abort write addr=10: ready=%0b", cur_ready);
    idle();
    xfer(32'h10, 1'b0, 32'h0, 4'h0, ok, n, rd, er); idle();
    chk("abort_readback", rd, 32'h0);

    // Zero-wait back-to-back writes then reads.
    dut_sel = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 4; i++) begin
      xfer(32'(4 * (i + 1)), 1'b1, 32'h1000_0001 * (i + 1), 4'hF, ok, n, rd, er);
      chk($sformatf("zw_wr%0d_cycles", i), 32'(n), 32'd1);
      chk($sformatf("zw_wr%0d_err", i), 32'(er), 32'd0);
    end
    chk("zw_wr_total_cycles", 32'(cyc - t0), 32'd8);
    t0 = cyc;
    for (int i = 0; i < 4; i++) begin
      xfer(32'(4 * (i + 1)), 1'b0, 32'h0, 4'h0, ok, n, rd, er);
      chk($sformatf("zw_rd%0d_cycles", i), 32'(n), 32'd1);
      chk($sformatf("zw_rd%0d_rdata", i), rd, 32'h1000_0001 * (i + 1));
    end
    chk("zw_rd_total_cycles", 32'(cyc - t0), 32'd8);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
